// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for a sync FIFO with occupancy count.
// Pulls fixed-length bursts (or a flushed partial burst) from the FIFO and
// forwards them on a valid/ready stream. A 2-entry buffer, whose head is the
// m_data/m_last register pair, hides the FIFO's 1-cycle read latency.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_empty,
  input  logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          fifo_rd_en,
  input  logic                          flush,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [15:0]                   word_cnt
);
  localparam int CW = $clog2(DATA_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         burst_len, burst_len_nxt;
  logic [CW-1:0]         issued;
  logic                  inflight, inflight_last, issue_last;
  logic                  accept;
  logic [1:0]            occ, occ_nxt;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] buf1, buf1_nxt, head_nxt;
  logic                  last1, last1_nxt, head_last_nxt;
  logic                  cap_to_head;

  assign accept  = m_valid & m_ready;
  assign busy    = (state != IDLE);
  // words held or on their way, after this cycle's handshake leaves
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, accept};

  // state, burst bookkeeping and delivered-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      burst_len     <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      word_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      burst_len     <= burst_len_nxt;
      if (state == IDLE)   issued <= '0;
      else if (fifo_rd_en) issued <= issued + CW'(1);
      // the in-flight word is dropped on reset because inflight clears
      inflight      <= fifo_rd_en;
      inflight_last <= issue_last;
      if (accept) word_cnt <= word_cnt + 16'd1;
    end
  end

  // next state, burst length latch and FIFO read issue
  always_comb begin
    state_nxt     = state;
    burst_len_nxt = burst_len;
    fifo_rd_en    = 1'b0;
    issue_last    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt >= CW'(BURST_LEN)) begin
          state_nxt     = BURST;
          burst_len_nxt = CW'(BURST_LEN);
        end else if (flush && !fifo_empty) begin
          state_nxt     = BURST;
          burst_len_nxt = fifo_cnt;
        end
      end
      BURST: begin
        fifo_rd_en = (issued < burst_len) && !fifo_empty && (pending < 3'd2);
        issue_last = fifo_rd_en && ((issued + CW'(1)) == burst_len);
        if (issue_last) state_nxt = DONE;
      end
      DONE: begin
        if (accept && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // buffer next values: pop head on accept, land returning word in first free slot
  always_comb begin
    head_nxt      = m_data;
    head_last_nxt = m_last;
    buf1_nxt      = buf1;
    last1_nxt     = last1;
    occ_nxt       = occ + {1'b0, inflight} - {1'b0, accept};
    cap_to_head   = (occ == 2'd0) || ((occ == 2'd1) && accept);
    if (accept) begin
      head_nxt      = buf1;
      head_last_nxt = last1;
    end
    if (inflight) begin
      if (cap_to_head) begin
        head_nxt      = fifo_dout;
        head_last_nxt = inflight_last;
      end else begin
        buf1_nxt      = fifo_dout;
        last1_nxt     = inflight_last;
      end
    end
    // keep m_last quiet while nothing is offered
    if (occ_nxt == 2'd0) head_last_nxt = 1'b0;
  end

  // buffer registers; head doubles as the registered stream output
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      buf1    <= '0;
      last1   <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      m_valid <= (occ_nxt != 2'd0);
      m_data  <= head_nxt;
      m_last  <= head_last_nxt;
      buf1    <= buf1_nxt;
      last1   <= last1_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, expected-stream queue built
// from the burst rules, and a negedge monitor for the stream/issue invariants.
module tb_fifo_burst_reader;
  localparam int DW = 8, DEPTH = 8, BL = 4, CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic          fifo_empty, fifo_rd_en, flush = 1'b0;
  logic [CW-1:0] fifo_cnt;
  logic [DW-1:0] fifo_dout = '0, m_data;
  logic          m_valid, m_last, m_ready = 1'b0, busy;
  logic [15:0]   word_cnt;

  fifo_burst_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .word_cnt(word_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // behavioural sync FIFO; cnt_bias lets a test overstate the occupancy
  logic [DW-1:0] mem [DEPTH];
  int   wp = 0, rp = 0, cnt = 0, pops = 0, cnt_bias = 0, cyc = 0;
  logic fifo_clr = 1'b0, wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      wp <= 0; rp <= 0; cnt <= 0; pops <= 0;
    end else begin
      if (fifo_rd_en && cnt > 0) begin
        fifo_dout <= mem[rp]; rp <= (rp + 1) % DEPTH; pops <= pops + 1;
      end
      if (wr_en && cnt < DEPTH) begin
        mem[wp] <= wr_data; wp <= (wp + 1) % DEPTH;
      end
      cnt <= cnt + int'(wr_en && cnt < DEPTH) - int'(fifo_rd_en && cnt > 0);
    end
  end
  assign fifo_empty = (cnt == 0);
  assign fifo_cnt   = CW'(cnt + cnt_bias);

  // expected delivered stream
  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  task automatic add_bursts(input logic [DW-1:0] w[$]);
    int n, full;
    exp_t e;
    n = w.size(); full = n / BL;
    for (int i = 0; i < n; i++) begin
      e.d = w[i];
      e.l = (i < full * BL) ? ((i % BL) == BL - 1) : (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // monitor: ordering, last flags, hold-while-stalled, issue limits
  int   iss = 0, accn = 0, first_rd = -1, first_v = -1, run1 = 0;
  logic run_open = 1'b0, stall_prev = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin : mon
    logic acc;
    exp_t e;
    acc = m_valid && m_ready;
    if (rst) begin
      iss = 0; accn = 0; first_rd = -1; first_v = -1; run1 = 0;
      run_open = 1'b0; stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      if (!m_valid) chk("last_without_valid", m_last, 0);
      if (fifo_rd_en) begin
        chk("rd_when_empty", fifo_empty, 0);
        chk("rd_outstanding", (iss - accn - int'(acc)) < 2, 1);
        if (first_rd < 0) begin first_rd = cyc; run_open = 1'b1; end
        if (run_open) run1++;
      end else if (first_rd >= 0) run_open = 1'b0;
      if (m_valid && first_v < 0) first_v = cyc;
      if (acc) begin
        if (exp_q.size() == 0) chk("extra_word", m_data, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.d);
          chk("last", m_last, e.l);
        end
      end
      iss  += int'(fifo_rd_en);
      accn += int'(acc);
      stall_prev = m_valid && !m_ready;
      pd = m_data; pl = m_last;
    end
  end

  // driver: 0 ready, 1 pattern 1,0,0,1, 2 random, 3 stalled
  int ready_mode = 0, ready_pct = 100, wr_pct = 100, pidx = 0;
  logic [DW-1:0] wq[$];
  task automatic tick();
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
      2:       m_ready = ($urandom_range(99) < ready_pct);
      default: m_ready = 1'b0;
    endcase
    pidx++;
    wr_en = 1'b0;
    if (wq.size() > 0 && cnt < DEPTH && $urandom_range(99) < wr_pct) begin
      wr_en = 1'b1; wr_data = wq.pop_front();
    end
    #1;
  endtask

  task automatic scn_start(input bit do_rst);
    if (do_rst) rst = 1'b1;
    fifo_clr = 1'b1; exp_q.delete(); wq.delete(); wr_en = 1'b0;
    flush = 1'b0; cnt_bias = 0; ready_mode = 0; wr_pct = 100;
    tick(); tick();
    fifo_clr = 1'b0; pidx = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && !(exp_q.size() == 0 && wq.size() == 0 && !busy); i++) tick();
    chk({"drain_", tag}, exp_q.size(), 0);
    chk({"idle_", tag}, busy, 0);
  endtask

  // finish full bursts, then flush the remaining rem words
  task automatic drain_flush(input string tag, input int rem);
    for (int i = 0; i < 3000 && !(exp_q.size() == rem && wq.size() == 0 && !busy); i++) tick();
    chk({"settle_", tag}, exp_q.size(), rem);
    if (rem > 0) begin
      flush = 1'b1; tick(); flush = 1'b0;
    end
    wait_drain(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pre[8];
    logic [DW-1:0] r[8];
    logic [DW-1:0] tmp[$];
    int n, lost;
    pre = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

    // reset values and burst timing
    scn_start(1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    tmp.delete(); foreach (pre[i]) tmp.push_back(pre[i]);
    wq = tmp; add_bursts(tmp);
    repeat (9) tick();
    rst = 1'b0;
    wait_drain("timing");
    chk("first_valid_latency", first_v - first_rd, 2);
    chk("first_rd_run", run1, 4);
    chk("timing_word_cnt", word_cnt, 8);
    chk("timing_empty", fifo_empty, 1);

    // backpressure 1,0,0,1
    scn_start(1);
    wq = tmp; add_bursts(tmp);
    repeat (9) tick();
    ready_mode = 1; rst = 1'b0;
    wait_drain("bp");
    chk("bp_word_cnt", word_cnt, 8);

    // flush of a 3-word partial burst
    scn_start(1);
    tmp = '{8'hA1, 8'hA2, 8'hA3};
    wq = tmp; add_bursts(tmp);
    repeat (4) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("flush_wait_busy", busy, 0);
    chk("flush_wait_reads", iss, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_drain("flush");
    chk("flush_reads", iss, 3);
    chk("flush_word_cnt", word_cnt, 3);

    // below threshold without flush, then crossing it
    scn_start(1);
    tmp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    add_bursts(tmp);
    wq = '{8'hB1, 8'hB2, 8'hB3};
    repeat (4) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("thresh_busy", busy, 0);
    chk("thresh_reads", iss, 0);
    wq.push_back(8'hB4);
    wait_drain("thresh");
    chk("thresh_word_cnt", word_cnt, 4);

    // FIFO runs dry mid-burst
    scn_start(1);
    tmp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    add_bursts(tmp);
    wq = '{8'hC1, 8'hC2};
    repeat (3) tick();
    cnt_bias = 2; rst = 1'b0;
    tick();
    cnt_bias = 0;
    repeat (10) tick();
    chk("dry_reads", iss, 2);
    chk("dry_busy", busy, 1);
    wq.push_back(8'hC3); wq.push_back(8'hC4);
    wait_drain("dry");
    chk("dry_word_cnt", word_cnt, 4);

    // reset while a word is offered and another is in flight
    scn_start(0);
    ready_mode = 3;
    foreach (r[i]) begin r[i] = DW'($urandom); wq.push_back(r[i]); end
    for (int i = 0; i < 50 && !m_valid; i++) tick();
    chk("rstmid_valid_seen", m_valid, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_m_valid", m_valid, 0);
    chk("rstmid_rd_en", fifo_rd_en, 0);
    chk("rstmid_word_cnt", word_cnt, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_m_last", m_last, 0);
    lost = pops;
    tmp.delete();
    for (int i = lost; i < 8; i++) tmp.push_back(r[i]);
    add_bursts(tmp);
    ready_mode = 0; rst = 1'b0;
    drain_flush("rstmid", tmp.size() % BL);
    chk("rstmid_word_cnt_end", word_cnt, 8 - lost);

    // randomized traffic, random backpressure, trickled writes
    for (int it = 0; it < 6; it++) begin
      scn_start(1);
      n = $urandom_range(5, 20);
      tmp.delete();
      for (int i = 0; i < n; i++) tmp.push_back(DW'($urandom));
      wq = tmp; add_bursts(tmp);
      ready_mode = 2; ready_pct = $urandom_range(30, 100); wr_pct = $urandom_range(20, 100);
      rst = 1'b0;
      drain_flush("rand", n % BL);
      chk("rand_word_cnt", word_cnt, n);
      chk("rand_empty", fifo_empty, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
